store_data_packer: RTL and testbench
====================================

Name: store_data_packer

Overview:
- Store-side counterpart of the immediate/load extenders. It narrows a 32-bit register value into the addressed byte or halfword lane of a data-memory word and generates byte enables.
- It runs a request/acknowledge write transaction to data memory. It sits between the EX/MEM store path and the data-memory port, and stalls the pipeline through st_ready.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles mem_req may stay high without mem_ack (used only with STORE_TIMEOUT_EN).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request from the pipeline.
- st_ready  output  1  block can accept a request.
- st_addr  input  32  byte address of the store.
- st_data  input  32  register value to store; low bits are used for byte and half stores.
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- mem_req  output  1  write request to data memory.
- mem_addr  output  32  word address, {st_addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit n covers mem_wdata[8n+7:8n].
- mem_ack  input  1  memory accepted the write.
- st_done  output  1  one-cycle pulse: store completed.
- st_misalign  output  1  one-cycle pulse: request rejected (misaligned address or reserved size).
- st_timeout  output  1  one-cycle pulse: request abandoned (only with STORE_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_done=0, st_misalign=0, st_timeout=0, counter=0.
  - st_ready=0 while rst_n=0 and 1 after release.
  - Reset mid-transaction drops mem_req immediately; no st_done is issued.
- States: IDLE, REQ.
- st_ready=1 only in IDLE when neither a st_done nor a st_misalign pulse is pending. A request is accepted when st_valid && st_ready at a rising edge.
- Byte order is little-endian. Lane rules at acceptance:
  - Byte: mem_wdata={4{st_data[7:0]}}, mem_be=4'b0001<<st_addr[1:0]. Always aligned.
  - Half: requires st_addr[0]=0. mem_wdata={2{st_data[15:0]}}, mem_be = st_addr[1] ? 4'b1100 : 4'b0011.
  - Word: requires st_addr[1:0]=0. mem_wdata=st_data, mem_be=4'b1111.
  - Size 11 or a misaligned address: no memory access. st_misalign pulses in the cycle after acceptance. State stays IDLE; st_ready is low for that one cycle.
- Accepted valid store:
  - At the accepting edge, register mem_addr, mem_wdata and mem_be, and go to REQ.
  - mem_req=1 from the next cycle. Outputs stay stable until the mem_ack edge.
- REQ state:
  - mem_ack sampled high at an edge: go to IDLE, drop mem_req, set mem_be=0, and pulse st_done for one cycle.
  - Minimum latency is acceptance edge to st_done = 2 cycles, with mem_ack in the first REQ cycle.
  - mem_ack while in IDLE is ignored.
- Back-to-back stores: the next request can be accepted in the cycle after the st_done pulse. There is no overlap and at most one outstanding write.
- mem_addr and mem_wdata hold their last values in IDLE; only mem_be clears.

Optional Feature:
- Macro STORE_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops, mem_be=0, st_timeout pulses for one cycle, and the state returns to IDLE.
  - If mem_ack arrives in the same cycle the count is reached, the ack wins: st_done pulses and st_timeout does not.
- Undefined:
  - No counter is built; st_timeout is tied to 0.
  - REQ waits indefinitely for mem_ack.

Test Plan:
1. Byte store: st_addr=0x1003, st_data=0xDEADBEA5, size=00, ack on the first REQ cycle → mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_be=1000; st_done 2 cycles after acceptance.
2. Half store: st_addr=0x2002, st_data=0x1234BEEF, size=01 → mem_wdata=0xBEEFBEEF, mem_be=1100. Repeat with st_addr=0x2001 → st_misalign pulse, mem_req never rises.
3. Word store: st_addr=0x3000, st_data=0xCAFEF00D, size=10, mem_ack delayed 5 cycles → mem_req held 5 cycles with stable outputs, then st_done. Repeat with st_addr=0x3002 → st_misalign pulse. Repeat with size=11 → st_misalign pulse.
4. Back-to-back: two word stores with st_valid held high → second accepted the cycle after the first st_done; never two mem_req transactions overlapping.
5. Reset mid-REQ: assert rst_n=0 while mem_req=1 → mem_req, mem_be and all pulses are 0 immediately (before the next edge); no st_done after release.
6. With STORE_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ack never asserted → st_timeout pulses after 16 REQ cycles and st_ready returns high. Second run with mem_ack on the 16th REQ cycle → st_done pulses, st_timeout does not.

Source files
------------

// File: rtl/store_data_packer_if.sv
// Store-path bundle between the pipeline EX/MEM stage, the store data packer
// and the data-memory write port. The packer uses the slave modport.
interface store_data_packer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        st_done;
    logic        st_misalign;
    logic        st_timeout;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               st_done, st_misalign, st_timeout
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               st_done, st_misalign, st_timeout
    );
endinterface

// File: rtl/store_data_packer.sv
// Steers a register value into its byte/halfword/word lane of a data-memory word and runs
// a req/ack write. Define STORE_TIMEOUT_EN to abandon writes after TIMEOUT_CYCLES cycles.
module store_data_packer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    store_data_packer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("CNT_W is too narrow to count to TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic        accept;
    logic        lane_ok;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
`ifdef STORE_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_q, timeout_d;
`endif

    // A pending done/misalign pulse holds off the next request for that one cycle.
    assign bus.st_ready = rst_n && (state_q == IDLE) && !done_q && !misalign_q;
    assign accept       = bus.st_valid && bus.st_ready;

    // Little-endian lane steering; narrow data is replicated so any lane sees it.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        lane_ok    = 1'b1;
        lane_wdata = bus.st_data;
        lane_be    = 4'b0000;
        case (bus.st_size)
            SIZE_BYTE: begin
                lane_wdata = {4{bus.st_data[7:0]}};
                lane_be    = 4'b0001 << bus.st_addr[1:0];
            end
            SIZE_HALF: begin
                lane_ok    = !bus.st_addr[0];
                lane_wdata = {2{bus.st_data[15:0]}};
                lane_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                lane_ok    = (bus.st_addr[1:0] == 2'b00);
                lane_be    = 4'b1111;
            end
            default: begin
                lane_ok    = 1'b0;
            end
        endcase
    end

`ifdef STORE_TIMEOUT_EN
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
`ifdef STORE_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lane_ok) begin
                        state_d = REQ;
                        addr_d  = {bus.st_addr[31:2], 2'b00};
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
`ifdef STORE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // An ack on the cycle the limit is reached still completes the store.
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    be_d    = 4'b0000;
                    done_d  = 1'b1;
                end
`ifdef STORE_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d   = IDLE;
                        be_d      = 4'b0000;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
`ifdef STORE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_be      = be_q;
    assign bus.st_done     = done_q;
    assign bus.st_misalign = misalign_q;
`ifdef STORE_TIMEOUT_EN
    assign bus.st_timeout  = timeout_q;
`else
    assign bus.st_timeout  = 1'b0;
`endif

    a_one_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({done_q, misalign_q, bus.st_timeout}));
    a_req_has_be: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_req |-> (be_q != 4'b0000));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.st_ready |-> !bus.mem_req);

endmodule

// File: tb/tb_store_data_packer.sv
// Randomized scoreboard bench for store_data_packer: a driver queues expected outcomes
// from an arithmetic lane model, a memory responder acks, and a monitor compares.
module tb_store_data_packer;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned NEVER          = 1000;

    typedef enum logic [1:0] {EV_DONE, EV_MISALIGN, EV_TIMEOUT} ev_t;

    typedef struct packed {
        ev_t         kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int unsigned accept_cyc;
        int unsigned req_cycles;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int unsigned last_event_cyc = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    int unsigned ack_q[$];

    store_data_packer_if bus ();

    store_data_packer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outcome from the lane rules, written as plain arithmetic.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [1:0] size, input int unsigned ack_delay);
        exp_t        e;
        int unsigned lane;
        bit          ok;
        lane  = addr % 4;
        e     = '0;
        e.addr = addr - lane;
        ok    = 1'b1;
        case (size)
            2'd0: begin
                e.wdata = (data & 32'h0000_00FF) * 32'h0101_0101;
                e.be    = 4'(1 << lane);
            end
            2'd1: begin
                ok      = (lane % 2 == 0);
                e.wdata = (data & 32'h0000_FFFF) * 32'h0001_0001;
                e.be    = 4'(3 << lane);
            end
            2'd2: begin
                ok      = (lane == 0);
                e.wdata = data;
                e.be    = 4'hF;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.kind       = EV_MISALIGN;
            e.req_cycles = 0;
        end
`ifdef STORE_TIMEOUT_EN
        else if (ack_delay >= TIMEOUT_CYCLES) begin
            e.kind       = EV_TIMEOUT;
            e.req_cycles = TIMEOUT_CYCLES;
        end
`endif
        else begin
            e.kind       = EV_DONE;
            e.req_cycles = ack_delay + 1;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         input int unsigned ack_delay, input bit hold, output int unsigned acc);
        int unsigned waited;
        exp_t        e;
        waited       = 0;
        acc          = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        while (!bus.st_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.st_ready) begin
            n_checks++;
            $display("FAIL accept_wait: st_ready still low after %0d cycles, want high", waited);
            bus.st_valid = 1'b0;
            return;
        end
        e            = model(addr, data, size, ack_delay);
        e.accept_cyc = cyc;
        acc          = cyc;
        exp_q.push_back(e);
        if (e.kind != EV_MISALIGN) ack_q.push_back(ack_delay);
        @(negedge clk);
        if (!hold) bus.st_valid = 1'b0;
    endtask

    // Memory responder: acks on REQ cycle (delay+1); stray acks while idle must be ignored.
    initial begin : responder
        int unsigned k;
        int unsigned d;
        bit          busy;
        bus.mem_ack = 1'b0;
        busy = 1'b0;
        k = 0;
        d = 0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rst_n || !bus.mem_req) begin
                busy = 1'b0;
                if (rst_n) bus.mem_ack = ($urandom_range(0, 3) == 0);
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    k    = 0;
                    d    = 0;
                    if (ack_q.size() != 0) d = ack_q.pop_front();
                end else begin
                    k++;
                end
                if (k == d) bus.mem_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        int unsigned req_cnt;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        logic [3:0]  held_be;
        bit          stable_ok;
        bit          overlap;
        ev_t         seen;
        exp_t        e;
        int          n_pulse;
        req_cnt = 0; stable_ok = 1'b1; overlap = 1'b0;
        held_addr = '0; held_wdata = '0; held_be = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cnt = 0; stable_ok = 1'b1; overlap = 1'b0;
                continue;
            end
            if (bus.mem_req) begin
                if (bus.st_ready) overlap = 1'b1;
                if (req_cnt == 0) begin
                    if (exp_q.size() != 0) begin
                        check("mem_addr",  bus.mem_addr,  exp_q[0].addr);
                        check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                        check("mem_be",    32'(bus.mem_be), 32'(exp_q[0].be));
                    end else begin
                        n_checks++;
                        $display("FAIL unexpected_mem_req: mem_req=1 with no store outstanding");
                    end
                    held_addr = bus.mem_addr; held_wdata = bus.mem_wdata; held_be = bus.mem_be;
                end else if (bus.mem_addr !== held_addr || bus.mem_wdata !== held_wdata
                             || bus.mem_be !== held_be) begin
                    stable_ok = 1'b0;
                end
                req_cnt++;
            end
            if (bus.st_done || bus.st_misalign || bus.st_timeout) begin
                n_pulse = int'(bus.st_done) + int'(bus.st_misalign) + int'(bus.st_timeout);
                seen = bus.st_done ? EV_DONE : (bus.st_misalign ? EV_MISALIGN : EV_TIMEOUT);
                last_event_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: done=%0b misalign=%0b timeout=%0b, want none",
                             bus.st_done, bus.st_misalign, bus.st_timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("single_pulse", 32'(n_pulse), 32'd1);
                    check("event_kind",   32'(seen), 32'(e.kind));
                    check("event_cycle",  cyc - e.accept_cyc, e.req_cycles + 1);
                    check("req_cycles",   req_cnt, e.req_cycles);
                    check("no_overlap",   32'(overlap), 32'd0);
                    if (e.kind != EV_TIMEOUT) check("ready_low_in_pulse", 32'(bus.st_ready), 32'd0);
                    if (e.kind != EV_MISALIGN) begin
                        check("mem_req_dropped", 32'(bus.mem_req), 32'd0);
                        check("mem_be_cleared",  32'(bus.mem_be), 32'd0);
                        check("outputs_stable",  32'(stable_ok), 32'd1);
                    end
                end
                req_cnt = 0; stable_ok = 1'b1; overlap = 1'b0;
            end
        end
    end

    initial begin : driver
        int unsigned acc;
        int unsigned acc2;
        int unsigned done_seen;
        int unsigned waited;
        int unsigned d;
        int unsigned r;
        logic [31:0] a;
        logic [1:0]  size;
        bit          hold;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req",     32'(bus.mem_req), 32'd0);
        check("rst_mem_addr",    bus.mem_addr, 32'd0);
        check("rst_mem_wdata",   bus.mem_wdata, 32'd0);
        check("rst_mem_be",      32'(bus.mem_be), 32'd0);
        check("rst_st_done",     32'(bus.st_done), 32'd0);
        check("rst_st_misalign", 32'(bus.st_misalign), 32'd0);
        check("rst_st_timeout",  32'(bus.st_timeout), 32'd0);
        check("rst_st_ready",    32'(bus.st_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_after_release", 32'(bus.st_ready), 32'd1);
        @(negedge clk);

        issue(32'h0000_1003, 32'hDEAD_BEA5, 2'b00, 0, 1'b0, acc);
        issue(32'h0000_2002, 32'h1234_BEEF, 2'b01, 2, 1'b0, acc);
        issue(32'h0000_2001, 32'h1234_BEEF, 2'b01, 0, 1'b0, acc);
        issue(32'h0000_3000, 32'hCAFE_F00D, 2'b10, 4, 1'b0, acc);
        issue(32'h0000_3002, 32'hCAFE_F00D, 2'b10, 0, 1'b0, acc);
        issue(32'h0000_3000, 32'hCAFE_F00D, 2'b11, 0, 1'b0, acc);

        // Back-to-back words with st_valid held: second accepted the cycle after st_done.
        issue(32'h0000_5000, 32'h0102_0304, 2'b10, 1, 1'b1, acc);
        issue(32'h0000_5004, 32'h0506_0708, 2'b10, 0, 1'b0, acc2);
        check("b2b_accept_gap", acc2 - last_event_cyc, 32'd1);

`ifdef STORE_TIMEOUT_EN
        issue(32'h0000_6000, 32'h0000_000A, 2'b10, NEVER, 1'b0, acc);
        issue(32'h0000_6004, 32'h0000_000B, 2'b10, TIMEOUT_CYCLES - 1, 1'b0, acc);
`endif

        // Reset in the middle of a transaction.
        issue(32'h0000_4000, 32'h1111_2222, 2'b10, 20, 1'b0, acc);
        @(negedge clk);
        check("req_before_reset", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req",     32'(bus.mem_req), 32'd0);
        check("midrst_mem_be",      32'(bus.mem_be), 32'd0);
        check("midrst_st_done",     32'(bus.st_done), 32'd0);
        check("midrst_st_misalign", 32'(bus.st_misalign), 32'd0);
        check("midrst_st_timeout",  32'(bus.st_timeout), 32'd0);
        check("midrst_st_ready",    32'(bus.st_ready), 32'd0);
        exp_q.delete();
        ack_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.st_done) done_seen++;
        end
        check("no_done_after_reset", done_seen, 32'd0);

        for (int i = 0; i < 200; i++) begin
            size = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) a[0] = 1'b0;
                else if (size == 2'd2) a[1:0] = 2'b00;
            end
            r = $urandom_range(0, 9);
            if (r < 7) d = $urandom_range(0, 3);
`ifdef STORE_TIMEOUT_EN
            else if (r < 9) d = $urandom_range(4, 14);
            else d = (r % 3 == 0) ? NEVER : $urandom_range(15, 16);
`else
            else d = $urandom_range(4, 20);
`endif
            hold = 1'($urandom_range(0, 1));
            issue(a, $urandom, size, d, hold, acc);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.st_valid = 1'b0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
